// File: rtl/arinc429_pkg.sv
// ARINC429 shared definitions: speed codes, word geometry, bit-period lookup and parity helper.
// Used by both the receive and transmit paths.
`timescale 1ns/1ps
package arinc429_pkg;

    typedef enum logic [1:0] {
        NVEL_12K5 = 2'd0,
        NVEL_50K  = 2'd1,
        NVEL_100K = 2'd2,
        NVEL_RSVD = 2'd3
    } nvel_e;

    localparam int WORD_BITS  = 32;
    localparam int LABEL_BITS = 8;
    localparam int DATA_BITS  = 23;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECV    = 2'd1,
        ST_DELIVER = 2'd2,
        ST_FLUSH   = 2'd3
    } rx_state_e;

    typedef enum logic [1:0] {
        LS_NULL = 2'd0,
        LS_ONE  = 2'd1,
        LS_ZERO = 2'd2,
        LS_ILL  = 2'd3
    } line_e;

    // Reserved code runs at the fastest rate.
    function automatic int bit_period(input int clk_hz, input logic [1:0] nvel);
        int t;
        case (nvel)
            2'd0:    t = clk_hz / 12500;
            2'd1:    t = clk_hz / 50000;
            default: t = clk_hz / 100000;
        endcase
        return t;
    endfunction

    function automatic logic odd_parity_ok(input logic [WORD_BITS-1:0] w);
        return ^w;
    endfunction

endpackage

// File: rtl/arinc429_rx_bitdet.sv
// ARINC429 line front end: synchronizer, line-state decode, T/4 glitch filter,
// NULL-duration counter. Emits one-cycle bit_vld/ill strobes and NULL-time levels.
`timescale 1ns/1ps
module arinc429_rx_bitdet
    import arinc429_pkg::*;
#(
    parameter int SYNC_FF = 2,
    parameter int CW      = 13
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_rxd0,
    input  logic          i_rxd1,
    input  logic [CW-1:0] i_qtr,
    input  logic [CW-1:0] i_two_t,
    output logic          o_bit_vld,
    output logic          o_bit_val,
    output logic          o_null_2t,
    output logic          o_null_gt2t,
    output logic          o_ill
);

    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [SYNC_FF-1:0] r_s0;
    logic [SYNC_FF-1:0] r_s1;
    logic               w_rx0;
    logic               w_rx1;
    line_e              w_ls;
    line_e              r_ls;
    logic [CW-1:0]      r_run;
    logic [CW-1:0]      w_run_nxt;
    logic [CW-1:0]      r_null;
    logic [CW-1:0]      w_null_nxt;
    logic               r_armed;
    logic               w_armed_nxt;
    logic               w_same;
    logic               w_hit;
    logic               w_bit_nxt;
    logic               w_ill_nxt;
    logic               r_bit_vld;
    logic               r_bit_val;
    logic               r_ill;
    logic               r_null_2t;
    logic               r_null_gt;

    // Metastability synchronizer for both line legs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s0 <= {SYNC_FF{1'b0}};
            r_s1 <= {SYNC_FF{1'b0}};
        end else begin
            r_s0 <= {r_s0[SYNC_FF-2:0], i_rxd0};
            r_s1 <= {r_s1[SYNC_FF-2:0], i_rxd1};
        end
    end

    assign w_rx0 = r_s0[SYNC_FF-1];
    assign w_rx1 = r_s1[SYNC_FF-1];

    // Line-state decode of the synchronized pair.
    always_comb begin
        w_ls = LS_NULL;
        case ({w_rx1, w_rx0})
            2'b10:   w_ls = LS_ONE;
            2'b01:   w_ls = LS_ZERO;
            2'b11:   w_ls = LS_ILL;
            default: w_ls = LS_NULL;
        endcase
    end

    // Run-length filter: a state fires exactly once when it has been stable for T/4 clocks.
    // A bit is only accepted when armed, i.e. the line has been NULL since the last bit.
    always_comb begin
        w_same = (w_ls == r_ls);
        if (!w_same) begin
            w_run_nxt = CNT_ONE;
        end else if (r_run >= i_qtr) begin
            w_run_nxt = r_run;
        end else begin
            w_run_nxt = r_run + CNT_ONE;
        end
        w_hit     = (w_run_nxt == i_qtr) && !(w_same && (r_run >= i_qtr));
        w_bit_nxt = w_hit && r_armed && ((w_ls == LS_ONE) || (w_ls == LS_ZERO));
        w_ill_nxt = w_hit && (w_ls == LS_ILL);
        if (w_ls == LS_NULL) begin
            w_armed_nxt = 1'b1;
        end else if (w_bit_nxt) begin
            w_armed_nxt = 1'b0;
        end else begin
            w_armed_nxt = r_armed;
        end
        if (w_ls != LS_NULL) begin
            w_null_nxt = {CW{1'b0}};
        end else if (r_null > i_two_t) begin
            w_null_nxt = r_null;
        end else begin
            w_null_nxt = r_null + CNT_ONE;
        end
    end

    // Filter state and registered strobes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ls      <= LS_NULL;
            r_run     <= {CW{1'b0}};
            r_null    <= {CW{1'b0}};
            r_armed   <= 1'b0;
            r_bit_vld <= 1'b0;
            r_bit_val <= 1'b0;
            r_ill     <= 1'b0;
            r_null_2t <= 1'b0;
            r_null_gt <= 1'b0;
        end else begin
            r_ls      <= w_ls;
            r_run     <= w_run_nxt;
            r_null    <= w_null_nxt;
            r_armed   <= w_armed_nxt;
            r_bit_vld <= w_bit_nxt;
            r_bit_val <= (w_ls == LS_ONE);
            r_ill     <= w_ill_nxt;
            r_null_2t <= (w_null_nxt >= i_two_t);
            r_null_gt <= (w_null_nxt > i_two_t);
        end
    end

    assign o_bit_vld   = r_bit_vld;
    assign o_bit_val   = r_bit_val;
    assign o_ill       = r_ill;
    assign o_null_2t   = r_null_2t;
    assign o_null_gt2t = r_null_gt;

endmodule

// File: rtl/arinc429_rx.sv
// ARINC429 receive channel: word FSM, shift register and host-side output registers.
// Optional feature macro: ARINC429_RX_PARITY_CHK_EN (odd-parity check, par_err strobe).
`timescale 1ns/1ps
module arinc429_rx
    import arinc429_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int SYNC_FF = 2
) (
    input  logic                  GCLK,
    input  logic                  RSTn,
    input  logic [1:0]            nvel,
    input  logic                  RXD0,
    input  logic                  RXD1,
    output logic [LABEL_BITS-1:0] sr_adr,
    output logic [DATA_BITS-1:0]  sr_dat,
    output logic                  ce_wr,
    output logic                  frm_err,
    output logic                  par_err,
    output logic                  busy
);

    localparam int T0 = bit_period(CLK_HZ, 2'd0);
    localparam int T1 = bit_period(CLK_HZ, 2'd1);
    localparam int T2 = bit_period(CLK_HZ, 2'd2);
    localparam int CW = $clog2(2 * T0 + 2);

    logic [1:0]           r_nvel;
    logic [CW-1:0]        w_t;
    logic [CW-1:0]        w_qtr;
    logic [CW-1:0]        w_two_t;
    logic                 w_bit_vld;
    logic                 w_bit_val;
    logic                 w_null_2t;
    logic                 w_null_gt2t;
    logic                 w_ill;
    rx_state_e            r_state;
    rx_state_e            w_state_nxt;
    logic [5:0]           r_cnt;
    logic [5:0]           w_cnt_nxt;
    logic [WORD_BITS-2:0] r_sh;
    logic [WORD_BITS-2:0] w_sh_nxt;
    logic [WORD_BITS-1:0] w_word;
    logic                 w_load;
    logic                 w_frm_nxt;
    logic [LABEL_BITS-1:0] r_adr;
    logic [DATA_BITS-1:0]  r_dat;
    logic                 r_ce;
    logic                 r_frm;
    logic                 r_busy;
`ifdef ARINC429_RX_PARITY_CHK_EN
    logic                 w_par_nxt;
    logic                 r_par;
`endif

    // Bit period for the speed latched at the start of the word.
    always_comb begin
        w_t = CW'(T2);
        case (r_nvel)
            2'd0:    w_t = CW'(T0);
            2'd1:    w_t = CW'(T1);
            default: w_t = CW'(T2);
        endcase
    end

    assign w_qtr   = w_t >> 2;
    assign w_two_t = w_t << 1;

    arinc429_rx_bitdet #(
        .SYNC_FF (SYNC_FF),
        .CW      (CW)
    ) u_bitdet (
        .i_clk       (GCLK),
        .i_rst_n     (RSTn),
        .i_rxd0      (RXD0),
        .i_rxd1      (RXD1),
        .i_qtr       (w_qtr),
        .i_two_t     (w_two_t),
        .o_bit_vld   (w_bit_vld),
        .o_bit_val   (w_bit_val),
        .o_null_2t   (w_null_2t),
        .o_null_gt2t (w_null_gt2t),
        .o_ill       (w_ill)
    );

    // Bits enter at the top and walk down, so bit 1 lands in word bit 0.
    assign w_word = {w_bit_val, r_sh};

    // Word FSM next-state and strobe decode; the output load happens on the bit-32 edge.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sh_nxt    = r_sh;
        w_load      = 1'b0;
        w_frm_nxt   = 1'b0;
`ifdef ARINC429_RX_PARITY_CHK_EN
        w_par_nxt   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_ill) begin
                    w_frm_nxt   = 1'b1;
                    w_state_nxt = ST_FLUSH;
                end else if (w_bit_vld) begin
                    w_sh_nxt    = w_word[WORD_BITS-1:1];
                    w_cnt_nxt   = 6'd1;
                    w_state_nxt = ST_RECV;
                end else begin
                    w_cnt_nxt   = 6'd0;
                end
            end
            ST_RECV: begin
                if (w_ill) begin
                    w_frm_nxt   = 1'b1;
                    w_cnt_nxt   = 6'd0;
                    w_state_nxt = ST_FLUSH;
                end else if (w_bit_vld) begin
                    w_sh_nxt  = w_word[WORD_BITS-1:1];
                    w_cnt_nxt = r_cnt + 6'd1;
                    if (r_cnt == 6'd31) begin
                        w_state_nxt = ST_DELIVER;
`ifdef ARINC429_RX_PARITY_CHK_EN
                        if (odd_parity_ok(w_word)) begin
                            w_load = 1'b1;
                        end else begin
                            w_par_nxt = 1'b1;
                        end
`else
                        w_load = 1'b1;
`endif
                    end else begin
                        w_state_nxt = ST_RECV;
                    end
                end else if (w_null_gt2t) begin
                    w_frm_nxt   = 1'b1;
                    w_cnt_nxt   = 6'd0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RECV;
                end
            end
            ST_DELIVER: begin
                w_cnt_nxt   = 6'd0;
                w_state_nxt = ST_IDLE;
            end
            ST_FLUSH: begin
                if (w_null_2t) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            default: begin
                w_cnt_nxt   = 6'd0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state, bit counter, shift register and speed latch.
    always_ff @(posedge GCLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= ST_IDLE;
            r_cnt   <= 6'd0;
            r_sh    <= {(WORD_BITS-1){1'b0}};
            r_nvel  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sh    <= w_sh_nxt;
            if (r_state == ST_IDLE) begin
                r_nvel <= nvel;
            end
        end
    end

    // Registered host outputs; label/data only move on a good delivery.
    always_ff @(posedge GCLK or negedge RSTn) begin
        if (!RSTn) begin
            r_adr  <= {LABEL_BITS{1'b0}};
            r_dat  <= {DATA_BITS{1'b0}};
            r_ce   <= 1'b0;
            r_frm  <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_ce   <= w_load;
            r_frm  <= w_frm_nxt;
            r_busy <= (w_state_nxt == ST_RECV) || (w_state_nxt == ST_FLUSH);
            if (w_load) begin
                r_adr <= w_word[LABEL_BITS-1:0];
                r_dat <= w_word[WORD_BITS-2:LABEL_BITS];
            end
        end
    end

`ifdef ARINC429_RX_PARITY_CHK_EN
    // Parity failure strobe.
    always_ff @(posedge GCLK or negedge RSTn) begin
        if (!RSTn) begin
            r_par <= 1'b0;
        end else begin
            r_par <= w_par_nxt;
        end
    end
    assign par_err = r_par;
`else
    assign par_err = 1'b0;
`endif

    assign sr_adr  = r_adr;
    assign sr_dat  = r_dat;
    assign ce_wr   = r_ce;
    assign frm_err = r_frm;
    assign busy    = r_busy;

endmodule
